// File: rtl/riscv_pkg.sv
// Shared RV32 datapath constants used by the operand-fetch stage and its register file.
package riscv_pkg;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // Number of source-operand read ports on the fetch stage.
  localparam int NRD = 2;

endpackage

// File: rtl/regfile_array.sv
// Integer register file: async-reset storage, one write port, NRD combinational read ports.
// x0 and indices at or above NREGS read as zero and are never written.
module regfile_array
  import riscv_pkg::REG_ZERO;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::AW,
  parameter int NRD   = riscv_pkg::NRD
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][XLEN-1:0]  rdata
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  function automatic logic live(input logic [AW-1:0] a);
    return (a != AW'(REG_ZERO)) && ({1'b0, a} < NREGS_W);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (we && live(waddr)) begin
      regs[waddr] <= wdata;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    assign rdata[p] = live(raddr[p]) ? regs[raddr[p]] : '0;
  end

endmodule

// File: rtl/operand_fetch.sv
// RV32 operand-fetch stage: reads rs1/rs2 with same-cycle writeback bypass and
// registers the pair into a single valid/ready output stage feeding the ALU.
module operand_fetch
  import riscv_pkg::REG_ZERO;
#(
  parameter int XLEN  = riscv_pkg::XLEN,
  parameter int NREGS = riscv_pkg::NREGS,
  parameter int AW    = riscv_pkg::AW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  output logic            op_valid,
  input  logic            op_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  localparam int          NP      = 2;
  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [NP-1:0][AW-1:0]   raddr;
  logic [NP-1:0][XLEN-1:0] rdata;
  logic [NP-1:0][XLEN-1:0] src;
  logic                    accept;
  logic                    wb_live;

  assign raddr = {rs2_addr, rs1_addr};

  regfile_array #(
    .XLEN (XLEN),
    .NREGS(NREGS),
    .AW   (AW),
    .NRD  (NP)
  ) u_rf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (wb_en),
    .waddr(wb_addr),
    .wdata(wb_data),
    .raddr(raddr),
    .rdata(rdata)
  );

  // A writeback that storage would ignore must not leak through the bypass either.
  assign wb_live = wb_en && (wb_addr != AW'(REG_ZERO)) && ({1'b0, wb_addr} < NREGS_W);

  for (genvar p = 0; p < NP; p++) begin : g_byp
    assign src[p] = (wb_live && wb_addr == raddr[p]) ? wb_data : rdata[p];
  end

  assign req_ready = !op_valid || op_ready;
  assign accept    = req_valid && req_ready;

  // Operands only move on accept, so a stall holds them even across writebacks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
    end else if (accept) begin
      op_valid <= 1'b1;
      op_a     <= src[0];
      op_b     <= src[1];
    end else if (op_ready) begin
      op_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: stimulus pushes expected pairs, a negedge
// monitor pops them whenever the DUT hands a pair to the consumer.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int errs   = 0;
  int checks = 0;
  logic [63:0] expq [$];

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a pair transfers on the next edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_n && op_valid && op_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pair", {op_a, op_b}, 64'hx);
      end else begin
        chk("pair", {op_a, op_b}, expq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_en = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] ea, input logic [31:0] eb);
    req_valid = 1'b1; rs1_addr = r1; rs2_addr = r2;
    expq.push_back({ea, eb});
    chk("req_ready_on_issue", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("drain_queue_empty", 64'(expq.size()), 64'd0);
    tick();
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rs1_addr = '0; rs2_addr = '0;
    op_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;

    // Reset then idle
    @(negedge clk);
    chk("rst_op_valid", {63'd0, op_valid}, 64'd0);
    chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("idle_op_valid", {63'd0, op_valid}, 64'd0);
    chk("idle_ops", {op_a, op_b}, 64'd0);
    chk("idle_req_ready", {63'd0, req_ready}, 64'd1);
    for (int i = 0; i < 32; i += 2) issue(5'(i), 5'(i + 1), 32'h0, 32'h0);
    drain();

    // Write then read
    wb(5'd5, 32'h12345678);
    wb(5'd6, 32'hFFFFFFFF);
    issue(5'd5, 5'd6, 32'h12345678, 32'hFFFFFFFF);

    // Same-cycle bypass, then a plain read of the written register
    wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEADBEEF;
    issue(5'd7, 5'd7, 32'hDEADBEEF, 32'hDEADBEEF);
    wb_en = 1'b0;
    issue(5'd7, 5'd0, 32'hDEADBEEF, 32'h0);

    // x0 writes ignored, including in the bypass cycle
    wb(5'd0, 32'hFFFFFFFF);
    issue(5'd0, 5'd0, 32'h0, 32'h0);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
    issue(5'd0, 5'd6, 32'h0, 32'hFFFFFFFF);
    wb_en = 1'b0;
    drain();

    // Backpressure with a writeback to a held source
    op_ready = 1'b0;
    req_valid = 1'b1; rs1_addr = 5'd5; rs2_addr = 5'd6;
    expq.push_back({32'h12345678, 32'hFFFFFFFF});
    tick();
    expq.push_back({32'h00000000, 32'hFFFFFFFF});
    wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_req_ready", {63'd0, req_ready}, 64'd0);
      chk("stall_held", {31'd0, op_valid, op_a}, {31'd0, 1'b1, 32'h12345678});
      @(posedge clk); #1;
      wb_en = 1'b0;
    end
    op_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    drain();

    // Reset mid-stall discards the pending pair and clears storage
    wb(5'd9, 32'hA5A5A5A5);
    op_ready = 1'b0;
    req_valid = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd9;
    tick();
    req_valid = 1'b0;
    chk("pre_rst_loaded", {31'd0, op_valid, op_a}, {31'd0, 1'b1, 32'hA5A5A5A5});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {63'd0, op_valid}, 64'd0);
    chk("async_rst_ops", {op_a, op_b}, 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    op_ready = 1'b1;
    tick();
    chk("post_rst_idle", {63'd0, op_valid}, 64'd0);
    issue(5'd9, 5'd5, 32'h0, 32'h0);
    issue(5'd7, 5'd6, 32'h0, 32'h0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage for the RV32 datapath; sits directly upstream of the ALU logic units (and2 and its siblings) and drives their 32-bit a/b operands.
- Holds the 32x32 integer register file and accepts the writeback port.
- Reads two source registers with write-to-read bypass, then registers the operands into a single valid/ready output stage.

Parameters:
XLEN, 32, data width of registers and operands
NREGS, 32, number of architectural registers
AW, 5, register address width (clog2 of NREGS)

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  upstream presents rs1_addr/rs2_addr
req_ready  output  1  stage can accept a request this cycle
rs1_addr  input  AW  source register 1 index
rs2_addr  input  AW  source register 2 index
op_valid  output  1  op_a/op_b hold a valid operand pair
op_ready  input  1  downstream ALU consumes the pair this cycle
op_a  output  XLEN  operand A (rs1 value), drives ALU a
op_b  output  XLEN  operand B (rs2 value), drives ALU b
wb_en  input  1  writeback strobe
wb_addr  input  AW  writeback destination index
wb_data  input  XLEN  writeback data

Behaviour:
- Reset (rst_n low, asynchronous): all NREGS registers = 0; op_valid = 0; op_a = op_b = 0. req_ready = 1 during and after reset (combinational, see below).
- Reset mid-operation: a pending pair is discarded. The cycle after release behaves as if idle.
- Register x0: always reads 0. Writes with wb_addr = 0 are ignored, so storage x0 stays 0.
- Writeback: if wb_en && wb_addr != 0, regs[wb_addr] <= wb_data on the rising edge.
- Acceptance:
  - req_ready = !op_valid || op_ready (combinational; single output stage, no skid buffer).
  - accept = req_valid && req_ready.
- Latency: 1 cycle. On the edge where accept = 1: op_valid <= 1, op_a <= src(rs1_addr), op_b <= src(rs2_addr).
- Bypass rule for src(r):
  - r == 0 -> 0.
  - else if wb_en && wb_addr == r -> wb_data, i.e. a same-cycle writeback is visible.
  - else -> regs[r].
  - Applies independently to both ports. rs1 == rs2 is legal and both get the same value.
- Drain: if op_valid && op_ready && !req_valid, then op_valid <= 0 and op_a/op_b keep their last values.
- Back-to-back: if op_valid && op_ready && req_valid, a new pair is loaded and op_valid stays 1. Full throughput is 1 pair per cycle.
- Stall: while op_valid && !op_ready, op_a/op_b/op_valid are held bit-stable. A writeback to a source register during the stall does NOT refresh the held operands. Hazard resolution belongs to the upstream hazard unit.
- Simultaneous writeback + stall: storage updates, outputs unchanged.
- Address out of range (NREGS < 2^AW): reads return 0, writes ignored.
- No X on outputs after reset, in any state.

Decomposition:
- Shared package (riscv_pkg): XLEN, NREGS, AW constants and the REG_ZERO index constant.
- One sub-module, regfile_array:
  - Storage, async reset, one write port, two combinational read ports.
  - Owns the x0 and out-of-range rules.
- operand_fetch owns:
  - the bypass muxes;
  - the valid/ready output register.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release -> op_valid=0, op_a=op_b=0x00000000, req_ready=1. Every reg read returns 0.
- Write then read: wb x5=0x12345678, x6=0xFFFFFFFF, then req rs1=5, rs2=6 with op_ready=1 -> next cycle op_valid=1, op_a=0x12345678, op_b=0xFFFFFFFF.
- Bypass: same cycle wb_en=1, wb_addr=7, wb_data=0xDEADBEEF and req rs1=7, rs2=7 -> op_a=op_b=0xDEADBEEF; a later read of x7 also returns 0xDEADBEEF.
- x0: wb x0=0xFFFFFFFF, then req rs1=0, rs2=0 (also in the bypass cycle) -> op_a=op_b=0x00000000.
- Backpressure:
  - load pair (x5, x6), then op_ready=0 for 3 cycles while req_valid=1 and wb x5=0x00000000 -> req_ready=0, op_a=0x12345678 held;
  - op_ready=1 -> queued request accepted next edge with op_a=0x00000000.
- Reset mid-stall: op_valid=1, op_ready=0, assert rst_n low asynchronously between edges -> op_valid=0 and op_a=op_b=0 immediately; regs cleared.
